// File: rtl/full_sub.sv
// full_sub: one-bit full subtractor, purely combinational.
// Computes a - b - bin for a single bit position.
// Ports:
//   a, b  : operand bits (minuend, subtrahend)
//   bin   : borrow in
//   diff  : difference bit
//   br    : borrow out (1 when a < b + bin)
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic br
);

  assign diff = a ^ b ^ bin;
  // Borrow when a=0 and b=1, or when a==b and a borrow is already coming in.
  assign br   = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial subtract sequencer.
// Computes {br, diff} = a - b - bin by pushing the operands LSB-first through
// one full_sub cell, one bit per clock, with the borrow held in a flop.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous reset, active-high
//   start  : request, accepted only in IDLE or DONE
//   a, b   : minuend / subtrahend, captured on the accepting edge
//   bin    : initial borrow-in, captured on the accepting edge
//   busy   : high while the operation is in flight
//   done   : one-cycle pulse when diff/br hold a new result
//   diff   : result register, a - b - bin mod 2^WIDTH
//   br     : final borrow-out
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; diff/br hold the last result
// RUN   | one operand bit per clock, cnt counts bits already done
// DONE  | one cycle with done=1; start here restarts immediately
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             br
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] rs;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             fs_diff;
  logic             fs_br;

  full_sub u_full_sub (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (borrow),
    .diff (fs_diff),
    .br   (fs_br)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      rs     <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      br     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // diff/br deliberately untouched: old result stays visible until
          // the new one lands.
          if (start) begin
            sa     <= a;
            sb     <= b;
            borrow <= bin;
            cnt    <= '0;
            state  <= RUN;
            busy   <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          borrow <= fs_br;
          // Result bits enter at the MSB so after WIDTH shifts bit 0 is the LSB.
          rs     <= {fs_diff, rs[WIDTH-1:1]};
          if (cnt == LAST) begin
            diff  <= {fs_diff, rs[WIDTH-1:1]};
            br    <= fs_br;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
